// File: rtl/alarm_controller_pkg.sv
// Shared definitions for the alarm controller: FSM state encoding and time-word layout.
// The optional snooze feature is selected by the ALARM_SNOOZE_EN macro (see alarm_controller.sv).
package alarm_controller_pkg;

    localparam int TIME_W = 13;

    // Time word: {pm, hr_tens, hr_units[3:0], min_tens[2:0], min_units[3:0]}
    localparam int MIN_UNITS_LSB = 0;
    localparam int MIN_TENS_LSB  = 4;
    localparam int HR_UNITS_LSB  = 7;
    localparam int HR_TENS_BIT   = 11;
    localparam int PM_BIT        = 12;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZING = 2'd3
    } state_e;

endpackage

// File: rtl/alarm_controller_if.sv
// Handshake bundle between timekeeping/buttons (master) and the alarm controller (slave).
interface alarm_controller_if;
    import alarm_controller_pkg::*;

    logic              tick_min;
    logic [TIME_W-1:0] cur_time;
    logic [TIME_W-1:0] alarm_time;
    logic              alarm_en;
    logic              snooze;
    logic              stop;
    logic              ring;
    logic [1:0]        state;
    logic [2:0]        snoozes_used;

    modport master (
        output tick_min, cur_time, alarm_time, alarm_en, snooze, stop,
        input  ring, state, snoozes_used
    );

    modport slave (
        input  tick_min, cur_time, alarm_time, alarm_en, snooze, stop,
        output ring, state, snoozes_used
    );
endinterface

// File: rtl/alarm_controller_cmp.sv
// 13-bit equality comparator between current time and alarm time.
module comparator_13bits
    import alarm_controller_pkg::*;
(
    input  logic [TIME_W-1:0] a_i,
    input  logic [TIME_W-1:0] b_i,
    output logic              eq_o
);
    assign eq_o = (a_i == b_i);
endmodule

// File: rtl/alarm_controller.sv
// Alarm sequencing FSM: fires on a rising time match, handles stop, snooze and ring timeout.
// Define ALARM_SNOOZE_EN to enable snoozing; otherwise the snooze input is ignored.
module alarm_controller
    import alarm_controller_pkg::*;
#(
    parameter int CNT_W            = 4,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic               clk,
    input  logic               reset,
    alarm_controller_if.slave  bus
);
    localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_TIMEOUT_MIN);
    localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_MIN);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(1);
    localparam logic [2:0]       USED_MAX    = 3'(MAX_SNOOZE);

    state_e           state_q;
    logic             ring_q;
    logic [2:0]       used_q;
    logic [CNT_W-1:0] cnt_q;
    logic             eq_q;
    logic             eq;
    logic             match_rise;
    logic             snooze_ok;
    logic             cnt_done;

    comparator_13bits u_cmp (
        .a_i  (bus.cur_time),
        .b_i  (bus.alarm_time),
        .eq_o (eq)
    );

    // eq_q resets to 1 so a time already matching at reset release cannot fire.
    assign match_rise = eq & ~eq_q;
    assign cnt_done   = bus.tick_min && (cnt_q == CNT_LAST);

`ifdef ALARM_SNOOZE_EN
    assign snooze_ok = bus.snooze && (used_q < USED_MAX);
`else
    logic unused_snooze;
    assign unused_snooze = bus.snooze;
    assign snooze_ok     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ring_q  <= 1'b0;
            used_q  <= '0;
            cnt_q   <= '0;
            eq_q    <= 1'b1;
        end else begin
            eq_q <= eq;
            if (!bus.alarm_en) begin
                state_q <= ST_IDLE;
                ring_q  <= 1'b0;
                used_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (match_rise) begin
                            state_q <= ST_RINGING;
                            ring_q  <= 1'b1;
                            cnt_q   <= RING_LOAD;
                            used_q  <= '0;
                        end
                    end
                    ST_RINGING: begin
                        if (bus.stop || cnt_done) begin
                            state_q <= ST_ARMED;
                            ring_q  <= 1'b0;
                            used_q  <= '0;
                        end else if (snooze_ok) begin
                            state_q <= ST_SNOOZING;
                            ring_q  <= 1'b0;
                            cnt_q   <= SNOOZE_LOAD;
                            used_q  <= used_q + 3'd1;
                        end else if (bus.tick_min) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_SNOOZING: begin
                        if (bus.stop) begin
                            state_q <= ST_ARMED;
                            ring_q  <= 1'b0;
                            used_q  <= '0;
                        end else if (cnt_done) begin
                            state_q <= ST_RINGING;
                            ring_q  <= 1'b1;
                            cnt_q   <= RING_LOAD;
                        end else if (bus.tick_min) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        ring_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ring         = ring_q;
    assign bus.state        = state_q;
    assign bus.snoozes_used = used_q;
endmodule
